// File: rtl/tm1638_pkg.sv
// ============================================================================
// Module      : tm1638_pkg
// Description : Shared command constants, frame and state encodings for the
//               TM1638 frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tm1638_pkg;

    localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
    localparam logic [7:0] CMD_ADDR0      = 8'hC0;
    localparam logic [7:0] CMD_DISP_CTRL  = 8'h80;
    localparam logic [7:0] CMD_READ_KEYS  = 8'h42;

    typedef enum logic [1:0] {
        FR_MODE = 2'd0,
        FR_DISP = 2'd1,
        FR_CTRL = 2'd2,
        FR_KEYS = 2'd3
    } frame_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BUSY  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_GAP   = 3'd4
    } seq_state_t;

    function automatic logic [7:0] cmd_byte(input frame_t f, input logic disp_on,
                                            input logic [2:0] bright);
        case (f)
            FR_MODE: return CMD_WRITE_AUTO;
            FR_DISP: return CMD_ADDR0;
            FR_CTRL: return CMD_DISP_CTRL | {4'b0000, disp_on, bright};
            default: return CMD_READ_KEYS;
        endcase
    endfunction

    function automatic logic [4:0] data_count(input frame_t f);
        case (f)
            FR_DISP: return 5'd16;
            FR_KEYS: return 5'd4;
            default: return 5'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/tm1638_frame_sequencer.sv
// ============================================================================
// Module      : tm1638_frame_sequencer
// Description : Runs the mode / display / control / key-read refresh cycle
//               against a TM1638 transceiver, with display buffer and key scan.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tm1638_frame_sequencer
    import tm1638_pkg::*;
#(
    parameter int GAP_CYCLES     = 50000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        disp_on,
    input  logic [2:0]  bright,
    input  logic        disp_we,
    input  logic [3:0]  disp_addr,
    input  logic [7:0]  disp_wdata,
    output logic        com_start,
    output logic        r_nw,
    output logic [4:0]  data_cnt,
    output logic [7:0]  wdata,
    input  logic        cmd_request,
    input  logic [4:0]  data_addr,
    input  logic [7:0]  rdata,
    input  logic        rdata_valid,
    input  logic        com_stop,
    output logic [31:0] keys,
    output logic        key_valid,
    output logic        key_change,
    output logic        busy,
    output logic        err_timeout
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    frame_t            r_f;
    frame_t            w_f_nxt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [WD_W-1:0]   r_wdog;
    logic              r_com_stop_d;
    logic              r_rdata_valid_d;
    logic              r_read;
    logic [4:0]        r_data_cnt;
    logic [7:0]        r_disp_buf [16];
    logic [7:0]        r_shadow   [16];
    logic [7:0]        r_key_tmp  [4];
    logic [31:0]       r_keys;
    logic              r_key_valid;
    logic              r_key_change;
    logic              w_stop_fall;
    logic              w_rv_rise;
    logic              w_timeout;
    logic [31:0]       w_key_word;
    logic [7:0]        w_cmd;

    assign w_stop_fall = r_com_stop_d & ~com_stop;
    assign w_rv_rise   = rdata_valid & ~r_rdata_valid_d;
    assign w_key_word  = {r_key_tmp[3], r_key_tmp[2], r_key_tmp[1], r_key_tmp[0]};
    assign w_cmd       = cmd_byte(r_f, disp_on, bright);

    always_comb begin
        w_state_nxt = r_state;
        w_f_nxt     = r_f;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_START;
                    w_f_nxt     = FR_MODE;
                end
            end
            ST_START: w_state_nxt = ST_BUSY;
            ST_BUSY: begin
                // A real completion wins over a watchdog expiry in the same cycle.
                if (w_stop_fall) begin
                    w_state_nxt = ST_NEXT;
                end else if (r_wdog == WD_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_GAP;
                    w_f_nxt     = FR_MODE;
                end
            end
            ST_NEXT: begin
                if (r_f == FR_KEYS) begin
                    w_state_nxt = ST_GAP;
                    w_f_nxt     = FR_MODE;
                end else if (en) begin
                    w_state_nxt = ST_START;
                    w_f_nxt     = frame_t'(r_f + 2'd1);
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_f_nxt     = FR_MODE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = en ? ST_START : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_f_nxt     = FR_MODE;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_f             <= FR_MODE;
            r_gap_cnt       <= '0;
            r_wdog          <= '0;
            r_com_stop_d    <= 1'b0;
            r_rdata_valid_d <= 1'b0;
            r_read          <= 1'b0;
            r_data_cnt      <= 5'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_f             <= w_f_nxt;
            r_com_stop_d    <= com_stop;
            r_rdata_valid_d <= rdata_valid;
            if ((r_state != ST_GAP) && (w_state_nxt == ST_GAP)) begin
                r_gap_cnt <= GAP_LOAD;
            end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
            if (r_state == ST_START) begin
                r_wdog <= '0;
            end else if (r_state == ST_BUSY) begin
                r_wdog <= r_wdog + WD_W'(1);
            end
            // Transaction attributes are latched on entry to START and held through BUSY.
            if (w_state_nxt == ST_START) begin
                r_read     <= (w_f_nxt == FR_KEYS);
                r_data_cnt <= data_count(w_f_nxt);
            end
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_disp_buf[i] <= 8'h00;
        end else if (disp_we) begin
            r_disp_buf[disp_addr] <= disp_wdata;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_shadow[i] <= 8'h00;
        end else if ((r_state == ST_START) && (r_f == FR_DISP)) begin
            r_shadow <= r_disp_buf;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_key_tmp[i] <= 8'h00;
            r_keys       <= 32'h0;
            r_key_valid  <= 1'b0;
            r_key_change <= 1'b0;
        end else begin
            r_key_valid  <= 1'b0;
            r_key_change <= 1'b0;
            if (w_timeout) begin
                for (int i = 0; i < 4; i++) r_key_tmp[i] <= 8'h00;
            end else if ((r_state == ST_BUSY) && (r_f == FR_KEYS) && w_rv_rise &&
                         (data_addr < 5'd4)) begin
                r_key_tmp[data_addr[1:0]] <= rdata;
            end
            if ((r_state == ST_NEXT) && (r_f == FR_KEYS)) begin
                r_keys       <= w_key_word;
                r_key_valid  <= 1'b1;
                r_key_change <= (w_key_word != r_keys);
            end
        end
    end

    assign com_start   = (r_state == ST_START);
    assign busy        = (r_state == ST_START) || (r_state == ST_BUSY) || (r_state == ST_NEXT);
    assign err_timeout = w_timeout;
    assign r_nw        = r_read;
    assign data_cnt    = r_data_cnt;
    assign keys        = r_keys;
    assign key_valid   = r_key_valid;
    assign key_change  = r_key_change;
    assign wdata       = cmd_request ? w_cmd :
                         ((r_f == FR_DISP) ? r_shadow[data_addr[3:0]] : 8'h00);

endmodule

`default_nettype wire

// File: tb/tb_tm1638_frame_sequencer.sv
// ============================================================================
// Module      : tb_tm1638_frame_sequencer
// Description : Self-checking bench with a transceiver model and a behavioural
//               reference for command bytes, display data and key scans.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tm1638_frame_sequencer;

    localparam int GAP = 100;
    localparam int TMO = 1000;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        disp_on = 1'b0;
    logic [2:0]  bright = 3'd0;
    logic        disp_we = 1'b0;
    logic [3:0]  disp_addr = 4'd0;
    logic [7:0]  disp_wdata = 8'd0;
    logic        cmd_request = 1'b0;
    logic [4:0]  data_addr = 5'd0;
    logic [7:0]  rdata = 8'd0;
    logic        rdata_valid = 1'b0;
    logic        com_stop = 1'b0;
    logic        com_start;
    logic        r_nw;
    logic [4:0]  data_cnt;
    logic [7:0]  wdata;
    logic [31:0] keys;
    logic        key_valid;
    logic        key_change;
    logic        busy;
    logic        err_timeout;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_fall = 0;
    int          t_start = 0;
    logic [7:0]  disp_model [16];
    logic [7:0]  key_bytes  [4];
    logic [31:0] keys_model = 32'h0;

    tm1638_frame_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .mclk(mclk), .rst_n(rst_n), .en(en), .disp_on(disp_on), .bright(bright),
        .disp_we(disp_we), .disp_addr(disp_addr), .disp_wdata(disp_wdata),
        .com_start(com_start), .r_nw(r_nw), .data_cnt(data_cnt), .wdata(wdata),
        .cmd_request(cmd_request), .data_addr(data_addr), .rdata(rdata),
        .rdata_valid(rdata_valid), .com_stop(com_stop), .keys(keys),
        .key_valid(key_valid), .key_change(key_change), .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_cmd(input int f);
        case (f)
            0:       return 8'h40;
            1:       return 8'hC0;
            2:       return 8'(8'h80 + (disp_on ? 8 : 0) + int'(bright));
            default: return 8'h42;
        endcase
    endfunction

    function automatic int model_cnt(input int f);
        return (f == 1) ? 16 : ((f == 3) ? 4 : 0);
    endfunction

    task automatic host_write(input int a, input logic [7:0] d);
        disp_we    = 1'b1;
        disp_addr  = 4'(a);
        disp_wdata = d;
        @(negedge mclk);
        disp_we    = 1'b0;
        disp_model[a] = d;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge mclk);
            if (com_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) t_start = cyc;
        else check_eq("start_seen", 32'd0, 32'd1);
    endtask

    // Plays the transceiver for one transaction of frame f and checks it.
    task automatic serve(input int f, input bit chk_t, input int exp_t,
                         input bit mid_write, input bit drop_en, input bit hang);
        bit          ok;
        logic [7:0]  snap [16];
        logic [31:0] exp_keys;
        snap = disp_model;
        wait_start(ok);
        if (!ok) return;
        if (chk_t) check_eq("start_cycle", 32'(t_start), 32'(exp_t));
        check_eq("r_nw", 32'(r_nw), 32'(f == 3));
        check_eq("data_cnt", 32'(data_cnt), 32'(model_cnt(f)));
        @(negedge mclk);
        check_eq("start_width", 32'(com_start), 32'd0);
        repeat ($urandom_range(0, 2)) @(negedge mclk);
        cmd_request = 1'b1;
        data_addr   = 5'd0;
        #1;
        check_eq("cmd_byte", 32'(wdata), 32'(model_cmd(f)));
        if (mid_write) host_write(3, 8'hAA);
        else @(negedge mclk);
        if (drop_en) en = 1'b0;
        cmd_request = 1'b0;
        if (f == 1) begin
            for (int i = 0; i < 16; i++) begin
                data_addr = 5'(i);
                #1;
                check_eq("disp_byte", 32'(wdata), 32'(snap[i]));
                @(negedge mclk);
            end
        end else if (f != 3) begin
            #1;
            check_eq("wdata_idle", 32'(wdata), 32'd0);
        end
        if (f == 3) begin
            for (int i = 0; i < 5; i++) begin
                data_addr = 5'(i);
                if (i < 4) rdata = key_bytes[i];
                else rdata = 8'hEE;
                rdata_valid = 1'b1;
                repeat (2) @(negedge mclk);
                rdata_valid = 1'b0;
                @(negedge mclk);
            end
        end
        com_stop = 1'b1;
        repeat (2) @(negedge mclk);
        if (hang) return;
        com_stop  = 1'b0;
        last_fall = cyc;
        @(negedge mclk);
        if (f == 3) begin
            exp_keys = {key_bytes[3], key_bytes[2], key_bytes[1], key_bytes[0]};
            @(negedge mclk);
            check_eq("key_valid", 32'(key_valid), 32'd1);
            check_eq("keys", keys, exp_keys);
            check_eq("key_change", 32'(key_change), 32'(exp_keys != keys_model));
            keys_model = exp_keys;
            @(negedge mclk);
            check_eq("key_valid_width", 32'(key_valid), 32'd0);
        end
    endtask

    task automatic run_scan(input bit chk_first);
        serve(0, chk_first, last_fall + 2 + GAP, 1'b0, 1'b0, 1'b0);
        serve(1, 1'b1, last_fall + 2, 1'b0, 1'b0, 1'b0);
        serve(2, 1'b1, last_fall + 2, 1'b0, 1'b0, 1'b0);
        serve(3, 1'b1, last_fall + 2, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        bit ok;
        int t_err;
        int n_starts;
        for (int i = 0; i < 16; i++) disp_model[i] = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge mclk);
        cmd_request = 1'b1;
        #1;
        check_eq("rst_wdata", 32'(wdata), 32'h40);
        check_eq("rst_com_start", 32'(com_start), 32'd0);
        check_eq("rst_r_nw", 32'(r_nw), 32'd0);
        check_eq("rst_data_cnt", 32'(data_cnt), 32'd0);
        check_eq("rst_keys", keys, 32'd0);
        check_eq("rst_key_valid", 32'(key_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(err_timeout), 32'd0);
        cmd_request = 1'b0;
        @(negedge mclk);
        rst_n = 1'b1;
        @(negedge mclk);

        for (int i = 0; i < 16; i++) host_write(i, 8'(i));
        disp_on = 1'b1;
        bright  = 3'd7;
        en      = 1'b1;

        key_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        serve(0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        serve(1, 1'b1, last_fall + 2, 1'b1, 1'b0, 1'b0);
        serve(2, 1'b1, last_fall + 2, 1'b0, 1'b0, 1'b0);
        serve(3, 1'b1, last_fall + 2, 1'b0, 1'b0, 1'b0);
        check_eq("keys_scan1", keys, 32'h44332211);

        run_scan(1'b1);
        key_bytes[2] = 8'h34;
        run_scan(1'b1);
        check_eq("keys_scan3", keys, 32'h44342211);

        for (int s = 0; s < 5; s++) begin
            repeat ($urandom_range(1, 6)) host_write(int'($urandom_range(0, 15)), 8'($urandom));
            disp_on = 1'($urandom);
            bright  = 3'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 4; k++) key_bytes[k] = 8'($urandom);
            end
            run_scan(1'b1);
        end

        for (int k = 0; k < 4; k++) key_bytes[k] = ~keys_model[8*k +: 8];
        serve(0, 1'b1, last_fall + 2 + GAP, 1'b0, 1'b0, 1'b0);
        serve(1, 1'b1, last_fall + 2, 1'b0, 1'b0, 1'b0);
        serve(2, 1'b1, last_fall + 2, 1'b0, 1'b0, 1'b0);
        serve(3, 1'b1, last_fall + 2, 1'b0, 1'b0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (err_timeout) begin
                ok = 1'b1;
                break;
            end
            @(negedge mclk);
        end
        t_err = cyc;
        check_eq("timeout_seen", 32'(ok), 32'd1);
        check_eq("timeout_at", 32'(t_err - t_start), 32'(TMO));
        check_eq("keys_after_timeout", keys, keys_model);
        @(negedge mclk);
        com_stop = 1'b0;
        check_eq("timeout_width", 32'(err_timeout), 32'd0);
        check_eq("busy_in_gap", 32'(busy), 32'd0);
        serve(0, 1'b1, t_err + 1 + GAP, 1'b0, 1'b0, 1'b0);

        serve(1, 1'b1, last_fall + 2, 1'b0, 1'b1, 1'b0);
        n_starts = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge mclk);
            if (com_start) n_starts++;
        end
        check_eq("no_start_en_low", 32'(n_starts), 32'd0);
        check_eq("idle_not_busy", 32'(busy), 32'd0);

        en = 1'b1;
        serve(0, 1'b1, cyc + 1, 1'b0, 1'b0, 1'b0);
        serve(1, 1'b1, last_fall + 2, 1'b0, 1'b0, 1'b0);
        serve(2, 1'b1, last_fall + 2, 1'b0, 1'b0, 1'b0);
        wait_start(ok);
        check_eq("read_rnw_before_rst", 32'(r_nw), 32'd1);
        @(negedge mclk);
        cmd_request = 1'b1;
        data_addr   = 5'd0;
        rdata       = 8'h55;
        rdata_valid = 1'b1;
        @(negedge mclk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_com_start", 32'(com_start), 32'd0);
        check_eq("arst_r_nw", 32'(r_nw), 32'd0);
        check_eq("arst_data_cnt", 32'(data_cnt), 32'd0);
        check_eq("arst_keys", keys, 32'd0);
        check_eq("arst_key_valid", 32'(key_valid), 32'd0);
        check_eq("arst_key_change", 32'(key_change), 32'd0);
        check_eq("arst_err", 32'(err_timeout), 32'd0);
        check_eq("arst_wdata", 32'(wdata), 32'h40);
        cmd_request = 1'b0;
        rdata_valid = 1'b0;
        en          = 1'b0;
        repeat (2) @(negedge mclk);
        rst_n = 1'b1;
        repeat (2) @(negedge mclk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
